// File: rtl/avr_serial_pkg.sv
// Shared types and constants for the AVR-bound serial transmitter.
package avr_serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } tx_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is refused while full even if a pop coincides.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/avr_serial_tx.sv
// Buffered UART transmitter toward the AVR: FIFO write port, configurable frame format,
// frames started only while the synchronised AVR busy line is low.
module avr_serial_tx
   import avr_serial_pkg::*;
#(
   parameter int unsigned CLK_PER_BIT = 100,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned PARITY      = PAR_NONE,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_BITS-1:0]           data,
   input  logic                           new_data,
   output logic                           ready,
   input  logic                           block,
   output logic                           tx,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
   output logic                           overflow
);

   localparam int unsigned TW = $clog2(STOP_BITS * CLK_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
   localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BITS * CLK_PER_BIT - 1);
   localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_BITS - 1);

   tx_state_e              state_q;
   logic [TW-1:0]          timer_q;
   logic [BW-1:0]          bitcnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_q;
   logic                   tx_q;
   logic                   block_s1_q;
   logic                   block_s_q;

   logic [DATA_BITS-1:0]   fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (new_data),
      .wdata (data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         block_s1_q <= 1'b0;
         block_s_q  <= 1'b0;
      end else begin
         block_s1_q <= block;
         block_s_q  <= block_s1_q;
      end
   end

   assign fifo_pop = (state_q == IDLE) && !fifo_empty && !block_s_q;

   // tx_q reflects the state held during the previous cycle, so the line trails the FSM by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  shift_q  <= fifo_rdata;
                  par_q    <= (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
                  bitcnt_q <= '0;
                  timer_q  <= '0;
                  state_q  <= START;
               end
            end
            START: begin
               tx_q <= 1'b0;
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  state_q <= DATA;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            DATA: begin
               tx_q <= shift_q[0];
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  shift_q <= shift_q >> 1;
                  if (bitcnt_q == DBIT_LAST) begin
                     state_q <= (PARITY != PAR_NONE) ? PAR : STOP;
                  end else begin
                     bitcnt_q <= bitcnt_q + BW'(1);
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            PAR: begin
               tx_q <= par_q;
               if (timer_q == BIT_LAST) begin
                  timer_q <= '0;
                  state_q <= STOP;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (timer_q == STOP_LAST) begin
                  timer_q <= '0;
                  state_q <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign ready    = !fifo_full;
   assign busy     = !fifo_empty || (state_q != IDLE);
   assign overflow = new_data && fifo_full;

endmodule

// File: tb/tb_avr_serial_tx.sv
// Bench for avr_serial_tx: four instances with different frame formats share one stimulus stream.
module tb_avr_serial_tx;

   localparam int CPB = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            new_data;
   logic            block;
   logic [7:0]      data;
   logic [3:0]      tx, busy, ready, ovf;
   logic [3:0][2:0] cnt;
   logic [7:0]      words [4];
   int              errors = 0;
   int              checks = 0;

   always #5 clk = ~clk;

   avr_serial_tx #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .ready(ready[0]), .block(block),
      .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt[0]), .overflow(ovf[0]));
   avr_serial_tx #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .ready(ready[1]), .block(block),
      .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt[1]), .overflow(ovf[1]));
   avr_serial_tx #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .ready(ready[2]), .block(block),
      .tx(tx[2]), .busy(busy[2]), .fifo_count(cnt[2]), .overflow(ovf[2]));
   avr_serial_tx #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .data(data), .new_data(new_data), .ready(ready[3]), .block(block),
      .tx(tx[3]), .busy(busy[3]), .fifo_count(cnt[3]), .overflow(ovf[3]));

   function automatic int par_of(int i);
      return (i == 1) ? 1 : (i == 2) ? 2 : 0;
   endfunction

   function automatic int stop_of(int i);
      return (i == 3) ? 2 : 1;
   endfunction

   function automatic int flen(int i);
      return CPB * (1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i));
   endfunction

   // Line level k cycles after the start-bit fall of a lone frame carrying w.
   function automatic logic line_bit(logic [7:0] w, int i, int k);
      int b;
      if (k < 0 || k >= flen(i)) return 1'b1;
      b = k / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return w[b-1];
      if (par_of(i) != 0 && b == 9) return (par_of(i) == 1) ? ^w : ~^w;
      return 1'b1;
   endfunction

   // Back-to-back frames from words[0..n-1], one idle cycle between frames.
   function automatic logic stream_bit(int i, int n, int k);
      int p;
      p = flen(i) + 1;
      if (k < 0 || (k / p) >= n) return 1'b1;
      return line_bit(words[k / p], i, k % p);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; new_data = 1'b0; block = 1'b0; data = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks += 5;
         if (tx[i] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d got=%b exp=1", i, tx[i]); end
         if (ready[i] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got=%b exp=1", i, ready[i]); end
         if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%b exp=0", i, busy[i]); end
         if (cnt[i] !== 3'd0) begin errors++; $display("FAIL reset_count dut%0d got=%0d exp=0", i, cnt[i]); end
         if (ovf[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf dut%0d got=%b exp=0", i, ovf[i]); end
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Push words[0..n-1] on consecutive edges; first push lands on edge N, sample k is taken after edge N+2+k.
   task automatic test_frames(input int n);
      int last, k, endk;
      logic e;
      last = 0;
      for (int i = 0; i < 4; i++) if (n * (flen(i) + 1) > last) last = n * (flen(i) + 1);
      for (int c = 0; c < last + 6; c++) begin
         @(negedge clk);
         k = c - 3;
         if (c >= 1) begin
            for (int i = 0; i < 4; i++) begin
               e = stream_bit(i, n, k);
               checks++;
               if (tx[i] !== e) begin
                  errors++;
                  $display("FAIL frame_tx dut%0d n=%0d k=%0d got=%b exp=%b", i, n, k, tx[i], e);
               end
               endk = (n - 1) * (flen(i) + 1) + flen(i);
               if (k <= endk - 2 || k >= endk) begin
                  e = (k <= endk - 2);
                  checks++;
                  if (busy[i] !== e) begin
                     errors++;
                     $display("FAIL frame_busy dut%0d n=%0d k=%0d got=%b exp=%b", i, n, k, busy[i], e);
                  end
               end
            end
         end
         if (c < n) begin data = words[c]; new_data = 1'b1; end
         else new_data = 1'b0;
      end
   endtask

   task automatic test_overflow_block();
      logic [7:0] extra;
      int k;
      logic e;
      block = 1'b1;
      repeat (3) @(negedge clk);
      for (int j = 0; j < 4; j++) words[j] = 8'($urandom);
      extra = 8'($urandom);
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         data = (p < 4) ? words[p] : extra;
         new_data = 1'b1;
         #1;
         for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (ovf[i] !== (p == 4)) begin errors++; $display("FAIL ovf_pulse dut%0d p=%0d got=%b exp=%b", i, p, ovf[i], p == 4); end
            if (ready[i] !== (p < 4)) begin errors++; $display("FAIL ovf_ready dut%0d p=%0d got=%b exp=%b", i, p, ready[i], p < 4); end
         end
      end
      @(negedge clk);
      new_data = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks += 3;
         if (cnt[i] !== 3'd4) begin errors++; $display("FAIL ovf_count dut%0d got=%0d exp=4", i, cnt[i]); end
         if (ready[i] !== 1'b0) begin errors++; $display("FAIL ovf_full dut%0d got=%b exp=0", i, ready[i]); end
         if (ovf[i] !== 1'b0) begin errors++; $display("FAIL ovf_clear dut%0d got=%b exp=0", i, ovf[i]); end
      end
      repeat (8) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (tx[i] !== 1'b1) begin errors++; $display("FAIL blocked_tx dut%0d got=%b exp=1", i, tx[i]); end
         end
      end
      block = 1'b0;
      for (int d = 1; d < 4 + 4 * 49 + 4; d++) begin
         @(negedge clk);
         k = d - 4;
         for (int i = 0; i < 4; i++) begin
            e = stream_bit(i, 4, k);
            checks++;
            if (tx[i] !== e) begin errors++; $display("FAIL drain_tx dut%0d k=%0d got=%b exp=%b", i, k, tx[i], e); end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (busy[i] !== 1'b0) begin errors++; $display("FAIL drain_busy dut%0d got=%b exp=0", i, busy[i]); end
      end
   endtask

   task automatic test_block_midframe();
      int k;
      logic e;
      words[0] = 8'($urandom);
      words[1] = 8'($urandom);
      for (int c = 0; c < 3 + 48 + 20; c++) begin
         @(negedge clk);
         k = c - 3;
         if (c >= 1) begin
            for (int i = 0; i < 4; i++) begin
               e = line_bit(words[0], i, k);
               checks++;
               if (tx[i] !== e) begin errors++; $display("FAIL midblk_tx dut%0d k=%0d got=%b exp=%b", i, k, tx[i], e); end
            end
         end
         new_data = 1'b0;
         if (c == 0) begin data = words[0]; new_data = 1'b1; end
         if (c == 13) begin block = 1'b1; data = words[1]; new_data = 1'b1; end
      end
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (cnt[i] !== 3'd1) begin errors++; $display("FAIL midblk_count dut%0d got=%0d exp=1", i, cnt[i]); end
         if (busy[i] !== 1'b1) begin errors++; $display("FAIL midblk_busy dut%0d got=%b exp=1", i, busy[i]); end
      end
      block = 1'b0;
      for (int d = 1; d < 4 + 48 + 4; d++) begin
         @(negedge clk);
         k = d - 4;
         for (int i = 0; i < 4; i++) begin
            e = line_bit(words[1], i, k);
            checks++;
            if (tx[i] !== e) begin errors++; $display("FAIL unblk_tx dut%0d k=%0d got=%b exp=%b", i, k, tx[i], e); end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int k;
      logic e;
      for (int j = 0; j < 4; j++) words[j] = 8'($urandom);
      for (int c = 0; c <= 17; c++) begin
         @(negedge clk);
         k = c - 3;
         if (c == 17) begin
            for (int i = 0; i < 4; i++) begin
               e = stream_bit(i, 4, k);
               checks += 2;
               if (tx[i] !== e) begin errors++; $display("FAIL prerst_tx dut%0d got=%b exp=%b", i, tx[i], e); end
               if (cnt[i] !== 3'd3) begin errors++; $display("FAIL prerst_count dut%0d got=%0d exp=3", i, cnt[i]); end
            end
         end
         if (c < 4) begin data = words[c]; new_data = 1'b1; end
         else new_data = 1'b0;
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks += 4;
         if (tx[i] !== 1'b1) begin errors++; $display("FAIL rst_tx dut%0d got=%b exp=1", i, tx[i]); end
         if (cnt[i] !== 3'd0) begin errors++; $display("FAIL rst_count dut%0d got=%0d exp=0", i, cnt[i]); end
         if (busy[i] !== 1'b0) begin errors++; $display("FAIL rst_busy dut%0d got=%b exp=0", i, busy[i]); end
         if (ready[i] !== 1'b1) begin errors++; $display("FAIL rst_ready dut%0d got=%b exp=1", i, ready[i]); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (tx[i] !== 1'b1) begin errors++; $display("FAIL postrst_tx dut%0d got=%b exp=1", i, tx[i]); end
            if (busy[i] !== 1'b0) begin errors++; $display("FAIL postrst_busy dut%0d got=%b exp=0", i, busy[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      words[0] = 8'hA5;
      test_frames(1);
      words[0] = 8'h07;
      test_frames(1);
      for (int r = 0; r < 3; r++) begin
         words[0] = 8'($urandom);
         test_frames(1);
      end
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 4; j++) words[j] = 8'($urandom);
         test_frames(int'($urandom_range(2, 4)));
      end
      test_overflow_block();
      repeat (4) @(negedge clk);
      test_block_midframe();
      repeat (4) @(negedge clk);
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
